// File: rtl/step_sequencer.sv
// ============================================================================
// step_sequencer -- debounced single-step / burst gate for CPU bus cycles.
// Optional breakpoint compare enabled by defining STEP_SEQUENCER_BREAK_EN.
// Revision: 1.0 -- initial release
// ============================================================================
`default_nettype none

module step_sequencer #(
    parameter int DEBOUNCE_CYCLES = 1024,
    parameter int COUNT_WIDTH     = 8,
    parameter int ADDR_WIDTH      = 24
) (
    input  logic                   CPUCLK_IN,
    input  logic                   RESET_IN,
    input  logic [1:0]             MODE_IN,
    input  logic                   STEP_IN,
    input  logic [COUNT_WIDTH-1:0] STEP_COUNT_IN,
    input  logic                   ENABLE_IN,
`ifdef STEP_SEQUENCER_BREAK_EN
    input  logic [ADDR_WIDTH-1:0]  ADDR_IN,
    input  logic [ADDR_WIDTH-1:0]  BREAK_ADDR_IN,
    input  logic                   BREAK_VALID_IN,
    output logic                   BREAK_HIT,
`endif
    output logic                   ENABLE_EXECUTE,
    output logic                   STEP_BUSY,
    output logic                   STEP_DONE,
    output logic [COUNT_WIDTH-1:0] REMAIN_OUT
);

    localparam int DCW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DCW-1:0] DB_LAST = DCW'(DEBOUNCE_CYCLES - 1);

    localparam logic [1:0] MODE_RUN    = 2'b00;
    localparam logic [1:0] MODE_SINGLE = 2'b01;
    localparam logic [1:0] MODE_BURST  = 2'b10;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        GRANT    = 2'd1,
        WAIT_REL = 2'd2
    } state_t;

    state_t                 state, state_n;
    logic [COUNT_WIDTH-1:0] remain, remain_n;
    logic                   done, done_n;
    logic                   exec, exec_n;
    logic                   en_d;
    logic                   fstep, fstep_d;
    logic [DCW-1:0]         db_cnt;

    logic                   cycle_end, fstep_rise, run_mode, step_mode, gate_open;
    logic [COUNT_WIDTH-1:0] burst_load;
    logic                   brk_block;

    assign cycle_end  = en_d & ~ENABLE_IN;
    assign fstep_rise = fstep & ~fstep_d;
    assign run_mode   = (MODE_IN == MODE_RUN);
    assign step_mode  = (MODE_IN == MODE_SINGLE) || (MODE_IN == MODE_BURST);
    assign gate_open  = run_mode || ((state == GRANT) && step_mode);
    assign burst_load = (STEP_COUNT_IN == '0) ? COUNT_WIDTH'(1) : STEP_COUNT_IN;

    // Debouncer: the filtered level flips only after an unbroken run of
    // disagreeing samples; any agreeing sample restarts the run.
    always_ff @(posedge CPUCLK_IN) begin
        if (RESET_IN) begin
            en_d    <= 1'b0;
            fstep   <= 1'b0;
            fstep_d <= 1'b0;
            db_cnt  <= '0;
        end else begin
            en_d    <= ENABLE_IN;
            fstep_d <= fstep;
            if (STEP_IN != fstep) begin
                if (db_cnt == DB_LAST) begin
                    fstep  <= ~fstep;
                    db_cnt <= '0;
                end else begin
                    db_cnt <= db_cnt + 1'b1;
                end
            end else begin
                db_cnt <= '0;
            end
        end
    end

`ifdef STEP_SEQUENCER_BREAK_EN
    logic brk_hit, brk_hit_n;
    logic brk_skip, brk_skip_n;
    logic brk_now;
    logic en_rise;

    assign en_rise   = ENABLE_IN & ~en_d;
    assign brk_now   = run_mode & en_rise & BREAK_VALID_IN & ~brk_skip &
                       (ADDR_IN == BREAK_ADDR_IN);
    assign brk_block = brk_now | brk_hit;

    // After a step releases the breakpoint, the next access is let through
    // uncompared so the stalled cycle at the break address can complete.
    always_comb begin
        brk_hit_n  = brk_hit;
        brk_skip_n = brk_skip;
        if (!run_mode) begin
            brk_hit_n  = 1'b0;
            brk_skip_n = 1'b0;
        end else if (brk_hit && fstep_rise) begin
            brk_hit_n  = 1'b0;
            brk_skip_n = 1'b1;
        end else begin
            if (brk_now) brk_hit_n = 1'b1;
            if (en_rise) brk_skip_n = 1'b0;
        end
    end

    always_ff @(posedge CPUCLK_IN) begin
        if (RESET_IN) begin
            brk_hit  <= 1'b0;
            brk_skip <= 1'b0;
        end else begin
            brk_hit  <= brk_hit_n;
            brk_skip <= brk_skip_n;
        end
    end

    assign BREAK_HIT = brk_hit;
`else
    assign brk_block = 1'b0;
`endif

    always_comb begin
        state_n  = state;
        remain_n = remain;
        done_n   = 1'b0;
        case (state)
            IDLE: begin
                if (step_mode && fstep_rise) begin
                    state_n  = GRANT;
                    remain_n = (MODE_IN == MODE_SINGLE) ? COUNT_WIDTH'(1) : burst_load;
                end
            end
            GRANT: begin
                if (step_mode && cycle_end) begin
                    if (remain <= COUNT_WIDTH'(1)) begin
                        remain_n = '0;
                        done_n   = 1'b1;
                        state_n  = WAIT_REL;
                    end else begin
                        remain_n = remain - 1'b1;
                    end
                end
            end
            WAIT_REL: begin
                if (!fstep) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
        if (run_mode) begin
            state_n  = IDLE;
            remain_n = '0;
            done_n   = 1'b0;
        end
        // A closed gate still lets an in-flight cycle finish rather than cut it.
        exec_n = (gate_open ? ENABLE_IN : (exec & ENABLE_IN)) & ~brk_block;
    end

    always_ff @(posedge CPUCLK_IN) begin
        if (RESET_IN) begin
            state  <= IDLE;
            remain <= '0;
            done   <= 1'b0;
            exec   <= 1'b0;
        end else begin
            state  <= state_n;
            remain <= remain_n;
            done   <= done_n;
            exec   <= exec_n;
        end
    end

    assign ENABLE_EXECUTE = exec;
    assign STEP_BUSY      = (state == GRANT);
    assign STEP_DONE      = done;
    assign REMAIN_OUT     = remain;

endmodule

`default_nettype wire

// File: tb/tb_step_sequencer.sv
// ============================================================================
// tb_step_sequencer -- directed vectors for step_sequencer (DEBOUNCE_CYCLES=8).
// Revision: 1.0 -- initial release
// ============================================================================
`default_nettype none

module tb_step_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] mode;
    logic       step_in;
    logic [7:0] step_count;
    logic       en_in;
    logic       exec, busy, done;
    logic [7:0] remain;
`ifdef STEP_SEQUENCER_BREAK_EN
    logic [23:0] addr, break_addr;
    logic        break_valid, break_hit;
`endif

    int n_vec = 0;
    int n_err = 0;
    int passed;
    int dones;

    always #5 clk = ~clk;

    step_sequencer #(
        .DEBOUNCE_CYCLES(8),
        .COUNT_WIDTH    (8),
        .ADDR_WIDTH     (24)
    ) dut (
        .CPUCLK_IN     (clk),
        .RESET_IN      (rst),
        .MODE_IN       (mode),
        .STEP_IN       (step_in),
        .STEP_COUNT_IN (step_count),
        .ENABLE_IN     (en_in),
`ifdef STEP_SEQUENCER_BREAK_EN
        .ADDR_IN       (addr),
        .BREAK_ADDR_IN (break_addr),
        .BREAK_VALID_IN(break_valid),
        .BREAK_HIT     (break_hit),
`endif
        .ENABLE_EXECUTE(exec),
        .STEP_BUSY     (busy),
        .STEP_DONE     (done),
        .REMAIN_OUT    (remain)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One two-clock bus cycle followed by two idle clocks.
    task automatic pulse();
        int ex;
        ex = 0;
        en_in = 1'b1;
        repeat (2) begin
            tick(1);
            ex += int'(exec);
            dones += int'(done);
        end
        en_in = 1'b0;
        repeat (2) begin
            tick(1);
            ex += int'(exec);
            dones += int'(done);
        end
        if (ex > 0) passed++;
    endtask

    initial begin
        rst = 1'b1; mode = 2'b00; step_in = 1'b0; step_count = 8'd0; en_in = 1'b0;
`ifdef STEP_SEQUENCER_BREAK_EN
        addr = 24'h0; break_addr = 24'h000400; break_valid = 1'b0;
`endif
        tick(3);
        check("rst_exec",   32'(exec),   32'd0);
        check("rst_busy",   32'(busy),   32'd0);
        check("rst_done",   32'(done),   32'd0);
        check("rst_remain", 32'(remain), 32'd0);
        rst = 1'b0;
        mode = 2'b01;
        tick(2);

        // Debounce: chatter every 3 clocks never reaches 8, then hold high.
        for (int i = 0; i < 4; i++) begin
            step_in = (i % 2 == 0);
            tick(3);
        end
        check("db_chatter", 32'(dut.fstep), 32'd0);
        step_in = 1'b1;
        tick(7);
        check("db_7th", 32'(dut.fstep), 32'd0);
        tick(1);
        check("db_8th", 32'(dut.fstep), 32'd1);
        tick(1);
        check("single_busy",   32'(busy),   32'd1);
        check("single_remain", 32'(remain), 32'd1);

        passed = 0; dones = 0;
        repeat (3) pulse();
        check("single_pass", 32'(passed), 32'd1);
        check("single_done", 32'(dones),  32'd1);
        tick(5);
        check("single_held_busy", 32'(busy), 32'd0);
        step_in = 1'b0;
        tick(10);

        // Burst of 5 with 7 requests.
        mode = 2'b10; step_count = 8'd5; step_in = 1'b1;
        tick(10);
        check("burst_busy",  32'(busy),   32'd1);
        check("burst_load",  32'(remain), 32'd5);
        passed = 0; dones = 0;
        for (int i = 1; i <= 7; i++) begin
            pulse();
            check("burst_rem", 32'(remain), (i < 5) ? 32'(5 - i) : 32'd0);
        end
        check("burst_pass", 32'(passed), 32'd5);
        check("burst_done", 32'(dones),  32'd1);
        step_in = 1'b0;
        tick(10);

        // Burst count of zero grants a single cycle.
        step_count = 8'd0; step_in = 1'b1;
        tick(10);
        check("zero_load", 32'(remain), 32'd1);
        passed = 0; dones = 0;
        repeat (3) pulse();
        check("zero_pass", 32'(passed), 32'd1);
        check("zero_done", 32'(dones),  32'd1);
        step_in = 1'b0;
        tick(10);

        // Run mode: one clock latency, no grant bookkeeping.
        mode = 2'b00;
        tick(2);
        en_in = 1'b1;
        check("run_lat0", 32'(exec), 32'd0);
        tick(1);
        check("run_lat1",   32'(exec),   32'd1);
        check("run_busy",   32'(busy),   32'd0);
        check("run_remain", 32'(remain), 32'd0);

        // Halt mid-cycle: cycle completes, exec falls one clock after en_in.
        mode = 2'b11;
        tick(1);
        check("halt_hold", 32'(exec), 32'd1);
        en_in = 1'b0;
        tick(1);
        check("halt_drop", 32'(exec), 32'd0);
        tick(2);
        passed = 0;
        pulse();
        check("halt_block", 32'(passed), 32'd0);

`ifdef STEP_SEQUENCER_BREAK_EN
        mode = 2'b00; break_valid = 1'b1; addr = 24'h000400;
        tick(2);
        passed = 0;
        pulse();
        check("brk_block", 32'(passed),    32'd0);
        check("brk_hit",   32'(break_hit), 32'd1);
        step_in = 1'b1;
        tick(10);
        check("brk_clear", 32'(break_hit), 32'd0);
        passed = 0;
        pulse();
        check("brk_step_pass", 32'(passed), 32'd1);
        step_in = 1'b0; break_valid = 1'b0;
        tick(10);
`endif

        // Reset during a grant with en_in high.
        mode = 2'b01; step_in = 1'b1;
        tick(10);
        check("rg_busy", 32'(busy), 32'd1);
        en_in = 1'b1;
        tick(1);
        check("rg_exec", 32'(exec), 32'd1);
        rst = 1'b1;
        tick(1);
        check("rg_rst_exec",   32'(exec),   32'd0);
        check("rg_rst_busy",   32'(busy),   32'd0);
        check("rg_rst_done",   32'(done),   32'd0);
        check("rg_rst_remain", 32'(remain), 32'd0);
        rst = 1'b0; en_in = 1'b0;
        tick(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
